mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multicycle sequencing controller for the MIPS datapath, replacing the single-cycle combinational `ctrl` decoder. It decodes `opcode`/`funct` from the instruction register and steps each instruction through FETCH, DECODE and execution states, so one shared ALU and one memory port serve every phase. It drives the existing control buses (`RegDst`, `AluSrc`, `MemWrite`, `RegWrite`, `wd_sel`, `NpcSel`, `ExtOp`, `AluCtrl`) plus the new `PcWrite`, `IrWrite` and `MemRead` strobes, and it reports illegal opcodes.

## Interface
- No parameters; all encodings are fixed.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `opcode` in 6: `IR[31:26]`, stable from DECODE until the next FETCH.
- `funct` in 6: `IR[5:0]`.
- `overflow` in 1: ALU signed-overflow flag for the current cycle.
- `mem_ready` in 1: memory handshake; used only with `MC_CTRL_MEMWAIT_EN`.
- `PcWrite` out 1: PC loads `npc` at the clock edge.
- `IrWrite` out 1: IR loads the memory output at the clock edge.
- `RegDst` out 2: write-register select. 0 = rt, 1 = rd, 2 = $31.
- `AluSrc` out 1: ALU B operand. 0 = rd2, 1 = extout.
- `MemRead` out 1, `MemWrite` out 1: data-memory strobes.
- `RegWrite` out 1: GPR write enable.
- `wd_sel` out 2: write-data select. 0 = ALU, 1 = memory, 2 = pc+4.
- `NpcSel` out 3: next-PC select. 0 = pc+4, 1 = beq (taken if zero), 2 = j/jal, 3 = jr (ALU target).
- `ExtOp` out 2: immediate extension. 0 = zero, 1 = sign, 2 = imm<<16.
- `AluCtrl` out 4: ALU operation. 0 = ADD, 1 = SUB, 2 = OR, 3 = SLT, 4 = PASS_A.
- `illegal` out 1: one-cycle pulse when an unsupported instruction retires.
- `state` out 4: current state code, for debug.

## Operation
- State codes: FETCH = 0, DECODE = 1, EXEC = 2, MEM_RD = 3, MEM_WR = 4, WB = 5, BRANCH = 6, JUMP = 7, TRAP = 8.
- Supported instructions:
  - R-type (opcode 000000): addu (100001), subu (100011), slt (101010), jr (001000).
  - I-type and J-type: addi (001000), ori (001101), lui (001111), lw (100011), sw (101011), beq (000100), j (000010), jal (000011).
- State actions:
  - FETCH: `IrWrite` = 1 and `MemRead` = 1. Next state is DECODE.
  - DECODE: no strobes. Next state is chosen by class:
    - R-ALU, addi, ori, lui, lw, sw go to EXEC.
    - beq goes to BRANCH.
    - j, jal, jr go to JUMP.
    - any other opcode, or an unsupported funct under opcode 000000, goes to TRAP.
  - EXEC: ALU controls are held.
    - R-ALU: `AluSrc` = 0; `AluCtrl` = ADD, SUB or SLT per funct.
    - addi, lw, sw: `ExtOp` = 1, ADD.
    - ori: `ExtOp` = 0, OR.
    - lui: `ExtOp` = 2, OR. The rs field of lui is 0, so the result is imm<<16.
    - Next state: lw goes to MEM_RD, sw goes to MEM_WR, all others go to WB.
  - MEM_RD: address controls held, `MemRead` = 1. Next state is WB.
  - MEM_WR: `MemWrite` = 1, `PcWrite` = 1, `NpcSel` = 0. Next state is FETCH.
  - WB: `RegWrite` = 1, `PcWrite` = 1, `NpcSel` = 0.
    - R-type: `RegDst` = 1. I-type: `RegDst` = 0.
    - `wd_sel` = 1 for lw, otherwise 0.
    - For addi with `overflow` = 1, `RegWrite` is forced to 0. The PC still advances.
    - Next state is FETCH.
  - BRANCH: `AluCtrl` = SUB, `AluSrc` = 0, `NpcSel` = 1, `PcWrite` = 1. Next state is FETCH.
  - JUMP: `PcWrite` = 1.
    - j: `NpcSel` = 2.
    - jal: `NpcSel` = 2, plus `RegWrite` = 1, `RegDst` = 2, `wd_sel` = 2.
    - jr: `NpcSel` = 3, `AluCtrl` = PASS_A.
    - Next state is FETCH.
  - TRAP: `illegal` = 1, `PcWrite` = 1, `NpcSel` = 0. Next state is FETCH.
- Any strobe not listed for a state is 0 in that state. Mux selects not listed are 0.

## Timing
- All outputs are combinational from `state` plus the registered IR fields. The state register is the only storage.
- Cycles per instruction (CPI): R-ALU, addi, ori, lui and sw take 4; lw takes 5; beq, j, jal, jr and illegal take 3.
- Each instruction asserts `PcWrite` exactly once, in its final state. `IrWrite` is asserted only in FETCH.
- Reset:
  - While `rst` = 0: `state` = FETCH and every strobe (`PcWrite`, `IrWrite`, `MemRead`, `MemWrite`, `RegWrite`, `illegal`) is forced to 0.
  - The first FETCH strobe appears in the cycle after `rst` rises.
  - Reset asserted mid-instruction aborts it immediately; no partial write occurs after the reset edge.
- `overflow` is sampled only in WB for addi and is ignored in all other states.

## Configuration
- `MC_CTRL_MEMWAIT_EN` defined: FETCH, MEM_RD and MEM_WR hold their state and their controls until `mem_ready` = 1.
  - `IrWrite` is asserted only in the FETCH cycle where `mem_ready` = 1.
  - In MEM_WR, `PcWrite` is asserted only in the cycle where `mem_ready` = 1. `MemWrite` stays high throughout the wait.
- `MC_CTRL_MEMWAIT_EN` undefined: the `mem_ready` port exists but is ignored. Every memory state takes exactly one cycle.

## Test plan
- Reset release, then addu (000000/100001): `state` sequence 0,1,2,5,0. In state 5, `RegWrite` = 1, `RegDst` = 1, `PcWrite` = 1.
- lw (100011): 5-cycle sequence 0,1,2,3,5. In state 5, `wd_sel` = 1. `MemWrite` is never 1.
- beq (000100) followed by jal (000011): each takes 3 cycles. beq shows `NpcSel` = 1. jal shows `RegDst` = 2, `wd_sel` = 2, `RegWrite` = 1.
- addi with `overflow` = 1 in WB: `RegWrite` = 0 and `PcWrite` = 1. Opcode 111111 goes to TRAP (state 8) with `illegal` = 1 for exactly one cycle.
- `rst` pulled low during MEM_WR of sw: `MemWrite` drops to 0 asynchronously and `state` = 0. After release, FETCH restarts.
- With `MC_CTRL_MEMWAIT_EN` and `mem_ready` held low for 3 cycles during FETCH: `state` stays 0 with `IrWrite` = 0. `IrWrite` = 1 on the `mem_ready` cycle, then DECODE follows.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle sequencing controller for the MIPS datapath.
// Walks each instruction through FETCH/DECODE/execution states so a single
// ALU and a single memory port serve every phase. The only storage is the
// state register; every output is decoded from state and the IR fields.
// Optional feature macro: MC_CTRL_MEMWAIT_EN (memory states stall on mem_ready).
module mc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    input  logic       mem_ready,
    output logic       PcWrite,
    output logic       IrWrite,
    output logic [1:0] RegDst,
    output logic       AluSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] wd_sel,
    output logic [2:0] NpcSel,
    output logic [1:0] ExtOp,
    output logic [3:0] AluCtrl,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_MEM_RD = 4'd3,
        S_MEM_WR = 4'd4,
        S_WB     = 4'd5,
        S_BRANCH = 4'd6,
        S_JUMP   = 4'd7,
        S_TRAP   = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        C_ADDU, C_SUBU, C_SLT, C_JR, C_ADDI, C_ORI, C_LUI,
        C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL
    } iclass_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_PASS = 4'd4;

    state_t  st, st_nxt;
    iclass_t ic;
    logic    mem_go;
    logic    r_type;
    logic    pc_w, ir_w, mr, mw, rw, ill;

`ifdef MC_CTRL_MEMWAIT_EN
    assign mem_go = mem_ready;
`else
    // Memory always completes in one cycle; mem_ready is intentionally unused.
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_go = 1'b1;
`endif

    assign r_type = (opcode == 6'b000000);
    assign state  = st;

    // Instruction class from the registered opcode/funct fields
    always_comb begin
        ic = C_ILL;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100001: ic = C_ADDU;
                    6'b100011: ic = C_SUBU;
                    6'b101010: ic = C_SLT;
                    6'b001000: ic = C_JR;
                    default:   ic = C_ILL;
                endcase
            end
            6'b001000: ic = C_ADDI;
            6'b001101: ic = C_ORI;
            6'b001111: ic = C_LUI;
            6'b100011: ic = C_LW;
            6'b101011: ic = C_SW;
            6'b000100: ic = C_BEQ;
            6'b000010: ic = C_J;
            6'b000011: ic = C_JAL;
            default:   ic = C_ILL;
        endcase
    end

    // Next-state selection; memory states stall only when the wait feature is built in
    always_comb begin
        st_nxt = S_FETCH;
        case (st)
            S_FETCH:  st_nxt = mem_go ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (ic)
                    C_ADDU, C_SUBU, C_SLT, C_ADDI, C_ORI,
                    C_LUI, C_LW, C_SW:   st_nxt = S_EXEC;
                    C_BEQ:               st_nxt = S_BRANCH;
                    C_J, C_JAL, C_JR:    st_nxt = S_JUMP;
                    default:             st_nxt = S_TRAP;
                endcase
            end
            S_EXEC: begin
                if (ic == C_LW)      st_nxt = S_MEM_RD;
                else if (ic == C_SW) st_nxt = S_MEM_WR;
                else                 st_nxt = S_WB;
            end
            S_MEM_RD: st_nxt = mem_go ? S_WB : S_MEM_RD;
            S_MEM_WR: st_nxt = mem_go ? S_FETCH : S_MEM_WR;
            default:  st_nxt = S_FETCH;
        endcase
    end

    // State register; reset aborts any instruction and restarts at FETCH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= S_FETCH;
        else      st <= st_nxt;
    end

    // Control decode; ALU/extend selects stay held from EXEC through the
    // final state because there is no ALU output register in the datapath
    always_comb begin
        pc_w    = 1'b0;
        ir_w    = 1'b0;
        mr      = 1'b0;
        mw      = 1'b0;
        rw      = 1'b0;
        ill     = 1'b0;
        RegDst  = 2'd0;
        AluSrc  = 1'b0;
        wd_sel  = 2'd0;
        NpcSel  = 3'd0;
        ExtOp   = 2'd0;
        AluCtrl = ALU_ADD;

        if (st == S_EXEC || st == S_MEM_RD || st == S_MEM_WR || st == S_WB) begin
            case (ic)
                C_ADDU: AluCtrl = ALU_ADD;
                C_SUBU: AluCtrl = ALU_SUB;
                C_SLT:  AluCtrl = ALU_SLT;
                C_ADDI, C_LW, C_SW: begin
                    AluSrc  = 1'b1;
                    ExtOp   = 2'd1;
                    AluCtrl = ALU_ADD;
                end
                C_ORI: begin
                    AluSrc  = 1'b1;
                    ExtOp   = 2'd0;
                    AluCtrl = ALU_OR;
                end
                C_LUI: begin
                    AluSrc  = 1'b1;
                    ExtOp   = 2'd2;
                    AluCtrl = ALU_OR;
                end
                default: ;
            endcase
        end

        case (st)
            S_FETCH: begin
                ir_w = mem_go;
                mr   = 1'b1;
            end
            S_MEM_RD: mr = 1'b1;
            S_MEM_WR: begin
                mw   = 1'b1;
                pc_w = mem_go;
            end
            S_WB: begin
                pc_w   = 1'b1;
                RegDst = r_type ? 2'd1 : 2'd0;
                wd_sel = (ic == C_LW) ? 2'd1 : 2'd0;
                rw     = !((ic == C_ADDI) && overflow);
            end
            S_BRANCH: begin
                AluCtrl = ALU_SUB;
                AluSrc  = 1'b0;
                NpcSel  = 3'd1;
                pc_w    = 1'b1;
            end
            S_JUMP: begin
                pc_w = 1'b1;
                if (ic == C_JR) begin
                    NpcSel  = 3'd3;
                    AluCtrl = ALU_PASS;
                end else begin
                    NpcSel = 3'd2;
                    if (ic == C_JAL) begin
                        rw     = 1'b1;
                        RegDst = 2'd2;
                        wd_sel = 2'd2;
                    end
                end
            end
            S_TRAP: begin
                ill  = 1'b1;
                pc_w = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are masked while reset is held so nothing writes during or
    // at the reset edge, even though the state already reads FETCH
    assign PcWrite  = pc_w & rst;
    assign IrWrite  = ir_w & rst;
    assign MemRead  = mr   & rst;
    assign MemWrite = mw   & rst;
    assign RegWrite = rw   & rst;
    assign illegal  = ill  & rst;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus a randomized
// instruction stream checked against a per-instruction cycle model.
module tb_mc_ctrl;

    logic       clk, rst;
    logic [5:0] opcode, funct;
    logic       overflow, mem_ready;
    logic       PcWrite, IrWrite, AluSrc, MemRead, MemWrite, RegWrite, illegal;
    logic [1:0] RegDst, wd_sel, ExtOp;
    logic [2:0] NpcSel;
    logic [3:0] AluCtrl, state;

    int vectors = 0;
    int miscompares = 0;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .overflow(overflow), .mem_ready(mem_ready),
        .PcWrite(PcWrite), .IrWrite(IrWrite), .RegDst(RegDst), .AluSrc(AluSrc),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .wd_sel(wd_sel), .NpcSel(NpcSel), .ExtOp(ExtOp), .AluCtrl(AluCtrl),
        .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Class ids: 0 addu 1 subu 2 slt 3 jr 4 addi 5 ori 6 lui 7 lw 8 sw
    //            9 beq 10 j 11 jal 12 illegal
    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: case (fn)
                6'b100001: return 0;
                6'b100011: return 1;
                6'b101010: return 2;
                6'b001000: return 3;
                default:   return 12;
            endcase
            6'b001000: return 4;
            6'b001101: return 5;
            6'b001111: return 6;
            6'b100011: return 7;
            6'b101011: return 8;
            6'b000100: return 9;
            6'b000010: return 10;
            6'b000011: return 11;
            default:   return 12;
        endcase
    endfunction

    // Runs one instruction from a FETCH negedge; checks every cycle.
    // ovf_mode: 0 random overflow each cycle, 1 held high, 2 held low.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int ovf_mode);
        int cls, n;
        int seq[$];
        logic last, ovf;
        logic [5:0] exp_strb, got_strb;
        int e_npc, e_rd, e_wd, e_alu, e_ext;
        cls = classify(op, fn);
        case (cls)
            0, 1, 2, 4, 5, 6: seq = '{0, 1, 2, 5};
            7:                seq = '{0, 1, 2, 3, 5};
            8:                seq = '{0, 1, 2, 4};
            9:                seq = '{0, 1, 6};
            3, 10, 11:        seq = '{0, 1, 7};
            default:          seq = '{0, 1, 8};
        endcase
        n = seq.size();
        opcode = op;
        funct  = fn;
        for (int k = 0; k < n; k++) begin
            ovf = (ovf_mode == 1) ? 1'b1 : (ovf_mode == 2) ? 1'b0 : 1'($urandom);
            overflow = ovf;
`ifndef MC_CTRL_MEMWAIT_EN
            mem_ready = 1'($urandom);
`endif
            #1;
            last = (k == n - 1);
            vectors++;
            if (state !== 4'(seq[k])) begin
                miscompares++;
                $display("FAIL state op=%b fn=%b cyc=%0d got=%0d exp=%0d", op, fn, k, state, seq[k]);
            end
            exp_strb = {last, k == 0, (k == 0) || (cls == 7 && k == 3),
                        cls == 8 && last,
                        last && (cls inside {0, 1, 2, 4, 5, 6, 7, 11}) && !(cls == 4 && ovf),
                        last && cls == 12};
            got_strb = {PcWrite, IrWrite, MemRead, MemWrite, RegWrite, illegal};
            vectors++;
            if (got_strb !== exp_strb) begin
                miscompares++;
                $display("FAIL strobes{pc,ir,mr,mw,rw,ill} op=%b fn=%b cyc=%0d got=%b exp=%b",
                         op, fn, k, got_strb, exp_strb);
            end
            e_npc = !last ? 0 : (cls == 9) ? 1 : (cls == 10 || cls == 11) ? 2 : (cls == 3) ? 3 : 0;
            e_rd  = !last ? 0 : (cls <= 2) ? 1 : (cls == 11) ? 2 : 0;
            e_wd  = !last ? 0 : (cls == 7) ? 1 : (cls == 11) ? 2 : 0;
            vectors++;
            if (NpcSel !== 3'(e_npc) || RegDst !== 2'(e_rd) || wd_sel !== 2'(e_wd)) begin
                miscompares++;
                $display("FAIL selects{npc,rd,wd} op=%b fn=%b cyc=%0d got=%0d,%0d,%0d exp=%0d,%0d,%0d",
                         op, fn, k, NpcSel, RegDst, wd_sel, e_npc, e_rd, e_wd);
            end
            if (k == 2 && seq[k] == 2) begin
                e_alu = (cls == 1) ? 1 : (cls == 2) ? 3 : (cls == 5 || cls == 6) ? 2 : 0;
                e_ext = (cls == 4 || cls == 7 || cls == 8) ? 1 : (cls == 6) ? 2 : 0;
                vectors++;
                if (AluCtrl !== 4'(e_alu) || ExtOp !== 2'(e_ext) || (cls <= 2 && AluSrc !== 1'b0)) begin
                    miscompares++;
                    $display("FAIL exec_alu op=%b fn=%b got alu=%0d ext=%0d src=%0d exp alu=%0d ext=%0d",
                             op, fn, AluCtrl, ExtOp, AluSrc, e_alu, e_ext);
                end
            end
            if (k == 2 && (cls == 9 || cls == 3)) begin
                e_alu = (cls == 9) ? 1 : 4;
                vectors++;
                if (AluCtrl !== 4'(e_alu) || (cls == 9 && AluSrc !== 1'b0)) begin
                    miscompares++;
                    $display("FAIL ctl_alu op=%b fn=%b got alu=%0d src=%0d exp alu=%0d",
                             op, fn, AluCtrl, AluSrc, e_alu);
                end
            end
            @(negedge clk);
        end
        overflow = 1'b0;
        mem_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            opcode = 6'($urandom);
            funct  = 6'($urandom);
            #1;
            vectors++;
            if (state !== 4'd0 || {PcWrite, IrWrite, MemRead, MemWrite, RegWrite, illegal} !== 6'b0) begin
                miscompares++;
                $display("FAIL reset_hold got state=%0d strobes=%b exp state=0 strobes=000000", state,
                         {PcWrite, IrWrite, MemRead, MemWrite, RegWrite, illegal});
            end
            @(negedge clk);
        end
        rst = 1'b1;
    endtask

    task automatic test_directed();
        run_instr(6'b000000, 6'b100001, 0);   // addu
        run_instr(6'b100011, 6'($urandom), 0); // lw
        run_instr(6'b000100, 6'($urandom), 0); // beq
        run_instr(6'b000011, 6'($urandom), 0); // jal
        run_instr(6'b001000, 6'($urandom), 1); // addi, overflow in WB
        run_instr(6'b001000, 6'($urandom), 2); // addi, no overflow
        run_instr(6'b111111, 6'($urandom), 0); // illegal opcode
        run_instr(6'b000000, 6'b111111, 0);   // illegal funct
        run_instr(6'b000000, 6'b001000, 0);   // jr
        run_instr(6'b001111, 6'($urandom), 0); // lui
    endtask

    task automatic test_reset_midwrite();
        opcode = 6'b101011;
        funct  = 6'($urandom);
        repeat (3) @(negedge clk);  // FETCH, DECODE, EXEC -> now MEM_WR
        #1;
        vectors++;
        if (state !== 4'd4 || MemWrite !== 1'b1) begin
            miscompares++;
            $display("FAIL sw_memwr got state=%0d mw=%b exp state=4 mw=1", state, MemWrite);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (state !== 4'd0 || MemWrite !== 1'b0 || PcWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_abort got state=%0d mw=%b pcw=%b exp 0,0,0", state, MemWrite, PcWrite);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (state !== 4'd0 || {PcWrite, IrWrite, MemRead, MemWrite, RegWrite, illegal} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_abort_hold got state=%0d strobes=%b exp 0,000000", state,
                     {PcWrite, IrWrite, MemRead, MemWrite, RegWrite, illegal});
        end
        @(negedge clk);
        rst = 1'b1;
        run_instr(6'b000000, 6'b100011, 0); // subu restarts cleanly
    endtask

`ifdef MC_CTRL_MEMWAIT_EN
    task automatic test_memwait();
        opcode = 6'b000010;
        funct  = 6'($urandom);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (state !== 4'd0 || IrWrite !== 1'b0 || MemRead !== 1'b1) begin
                miscompares++;
                $display("FAIL fetch_wait got state=%0d ir=%b mr=%b exp 0,0,1", state, IrWrite, MemRead);
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        vectors++;
        if (state !== 4'd0 || IrWrite !== 1'b1) begin
            miscompares++;
            $display("FAIL fetch_ready got state=%0d ir=%b exp 0,1", state, IrWrite);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (state !== 4'd1) begin
            miscompares++;
            $display("FAIL fetch_to_decode got state=%0d exp 1", state);
        end
        repeat (2) @(negedge clk);  // JUMP, then back at FETCH
    endtask
`endif

    task automatic test_back_to_back();
        logic [6:0][5:0] ops;
        logic [5:0] op, fn;
        int pick;
        ops = {6'b001000, 6'b001101, 6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
        for (int i = 0; i < 300; i++) begin
            pick = int'($urandom_range(0, 12));
            fn = 6'($urandom);
            if (pick < 7) begin
                op = ops[pick];
            end else if (pick < 11) begin
                op = 6'b000000;
                case (pick)
                    7:       fn = 6'b100001;
                    8:       fn = 6'b100011;
                    9:       fn = 6'b101010;
                    default: fn = 6'b001000;
                endcase
            end else if (pick == 11) begin
                op = 6'b000011;
            end else begin
                op = 6'($urandom);
                for (int t = 0; t < 50 && classify(op, fn) != 12; t++) begin
                    op = 6'($urandom);
                    fn = 6'($urandom);
                end
            end
            run_instr(op, fn, 0);
        end
    endtask

    initial begin
        rst = 1'b0;
        opcode = '0;
        funct = '0;
        overflow = 1'b0;
        mem_ready = 1'b1;
        test_reset();
        test_directed();
`ifdef MC_CTRL_MEMWAIT_EN
        test_memwait();
`endif
        test_reset_midwrite();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
